program_counter_stack: RTL

Parametrised next-generation program counter for the 8-bit bus CPU. It supports increment, absolute jump, subroutine call and return through an internal LIFO return-address stack. The count drives the shared tri-state bus on request. The control sequencer issues one-cycle command strobes, and the block reports stack status and sticky error flags for debug and halt logic.

---
 rtl/pc_pkg.sv | 31 +++
 rtl/program_counter_stack_return_stack.sv | 47 ++++
 rtl/program_counter_stack.sv | 107 ++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared command encoding, decode helper and default parameters for the program counter.
package pc_pkg;

    localparam int unsigned PC_ADDR_W      = 4;
    localparam int unsigned PC_BUS_W       = 8;
    localparam int unsigned PC_STACK_DEPTH = 4;
    localparam int unsigned PC_RESET_ADDR  = 0;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INC,
        PC_JUMP,
        PC_CALL,
        PC_RET,
        PC_ILLEGAL
    } pc_cmd_e;

    // More than one strobe in a cycle is illegal and must not move the count.
    function automatic pc_cmd_e decode_cmd(input logic inc, input logic jump,
                                           input logic call, input logic ret);
        case ({inc, jump, call, ret})
            4'b0000: return PC_HOLD;
            4'b1000: return PC_INC;
            4'b0100: return PC_JUMP;
            4'b0010: return PC_CALL;
            4'b0001: return PC_RET;
            default: return PC_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/program_counter_stack_return_stack.sv
// LIFO of return addresses; push ignored when full, pop ignored when empty.
module return_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top_data,
    output logic         empty,
    output logic         full
);

    localparam int unsigned SP_W  = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SP_W-1:0]  sp;
    logic [W-1:0]     mem [DEPTH];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    assign wr_idx   = IDX_W'(sp);
    assign rd_idx   = IDX_W'(sp - SP_W'(1));
    assign empty    = (sp == '0);
    assign full     = (sp == SP_W'(DEPTH));
    assign top_data = mem[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp <= sp - SP_W'(1);
        end
    end

    // Entry contents need no reset; only the pointer defines validity.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/program_counter_stack.sv
// Program counter with increment/jump/call/return, tri-state bus drive and sticky error flags.
module program_counter_stack
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W      = PC_ADDR_W,
    parameter int unsigned BUS_W       = PC_BUS_W,
    parameter int unsigned STACK_DEPTH = PC_STACK_DEPTH,
    parameter int unsigned RESET_ADDR  = PC_RESET_ADDR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              jump,
    input  logic              call,
    input  logic              ret,
    input  logic              out,
    inout  wire  [BUS_W-1:0]  bus,
    output logic [ADDR_W-1:0] pc,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              err_overflow,
    output logic              err_underflow,
    output logic              err_cmd
);

    pc_cmd_e           cmd;
    logic [ADDR_W-1:0] count;
    logic [ADDR_W-1:0] count_next;
    logic [ADDR_W-1:0] load_val;
    logic [ADDR_W-1:0] top_data;
    logic [BUS_W-1:0]  bus_drive;
    logic              push;
    logic              pop;
    logic              ovf_next;
    logic              unf_next;
    logic              cmd_next;

    return_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (count + ADDR_W'(1)),
        .top_data  (top_data),
        .empty     (stack_empty),
        .full      (stack_full)
    );

    always_comb begin
        bus_drive                = '0;
        bus_drive[ADDR_W-1:0]    = count;
    end

    assign bus      = out ? bus_drive : 'z;
    assign load_val = ADDR_W'(bus);
    assign pc       = count;

    always_comb begin
        cmd        = decode_cmd(inc, jump, call, ret);
        count_next = count;
        push       = 1'b0;
        pop        = 1'b0;
        ovf_next   = err_overflow;
        unf_next   = err_underflow;
        cmd_next   = err_cmd;
        case (cmd)
            PC_INC:  count_next = count + ADDR_W'(1);
            PC_JUMP: count_next = load_val;
            PC_CALL: begin
                if (stack_full) begin
                    ovf_next = 1'b1;
                end else begin
                    push       = 1'b1;
                    count_next = load_val;
                end
            end
            PC_RET: begin
                if (stack_empty) begin
                    unf_next = 1'b1;
                end else begin
                    pop        = 1'b1;
                    count_next = top_data;
                end
            end
            PC_ILLEGAL: cmd_next = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count         <= ADDR_W'(RESET_ADDR);
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            err_cmd       <= 1'b0;
        end else begin
            count         <= count_next;
            err_overflow  <= ovf_next;
            err_underflow <= unf_next;
            err_cmd       <= cmd_next;
        end
    end

endmodule
